// File: rtl/mul_fp32bit_pkg.sv
// Shared fixed-point constants and sequencer states for the HDR arithmetic path
// (common to mul_fp32bit and div_fp32bit).
package mul_fp32bit_pkg;

   localparam int unsigned FP_N    = 32;
   localparam int unsigned FP_FRAC = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } fp_state_t;

endpackage

// File: rtl/mul_fp32bit.sv
// Sequential unsigned Q(N-FP).FP multiplier: radix-2 shift-add over N cycles,
// truncated result with high-bit overflow flag, divider-compatible handshake.
module mul_fp32bit
   import mul_fp32bit_pkg::*;
#(
   parameter int unsigned N  = FP_N,
   parameter int unsigned FP = FP_FRAC
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] A,
   input  logic [N-1:0] B,
   input  logic         valid,
   output logic [N-1:0] OUT,
   output logic         ovrflow,
   output logic         ready,
   output logic         busy
);

   localparam int unsigned CW = $clog2(N);
   localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

   fp_state_t        state, state_nxt;
   logic [2*N-1:0]   acc;
   logic [2*N-1:0]   a_sh;
   logic [N-1:0]     b_sh;
   logic [CW-1:0]    cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      busy      = 1'b1;
      unique case (state)
         IDLE: begin
            busy = 1'b0;
            if (valid) state_nxt = RUN;
         end
         RUN:     if (cnt == CNT_LAST) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc     <= '0;
         a_sh    <= '0;
         b_sh    <= '0;
         cnt     <= '0;
         OUT     <= '0;
         ovrflow <= 1'b0;
         ready   <= 1'b0;
      end else begin
         ready <= (state == DONE);
         unique case (state)
            IDLE: begin
               if (valid) begin
                  a_sh <= {{N{1'b0}}, A};
                  b_sh <= B;
                  acc  <= '0;
                  cnt  <= '0;
               end
            end
            RUN: begin
               if (b_sh[0]) acc <= acc + a_sh;
               a_sh <= a_sh << 1;
               b_sh <= b_sh >> 1;
               cnt  <= cnt + 1'b1;
            end
            DONE: begin
               // Drop the FP fraction bits; anything above N+FP is lost integer range.
               OUT     <= acc[N+FP-1:FP];
               ovrflow <= |acc[2*N-1:N+FP];
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mul_fp32bit.sv
// Directed and randomized self-checking bench for mul_fp32bit.
module tb_mul_fp32bit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] A = '0;
   logic [31:0] B = '0;
   logic        valid = 1'b0;
   logic [31:0] OUT;
   logic        ovrflow;
   logic        ready;
   logic        busy;

   int n_cmp = 0;
   int n_err = 0;

   mul_fp32bit #(.N(32), .FP(8)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .A       (A),
      .B       (B),
      .valid   (valid),
      .OUT     (OUT),
      .ovrflow (ovrflow),
      .ready   (ready),
      .busy    (busy)
   );

   always #5 clk = ~clk;

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   // Drive one valid pulse; the sampling edge is consumed here.
   task automatic start_op(input logic [31:0] a, input logic [31:0] b);
      A     = a;
      B     = b;
      valid = 1'b1;
      step();
      valid = 1'b0;
   endtask

   // Steps until ready, returning cycles since the sampling edge (-1 on timeout)
   // and the number of samples with busy high before ready.
   task automatic wait_ready(output int cyc, output int busy_cyc);
      cyc      = 0;
      busy_cyc = busy ? 1 : 0;
      for (int i = 1; i <= 100; i++) begin
         step();
         if (ready) begin
            cyc = i;
            return;
         end
         if (busy) busy_cyc++;
      end
      cyc = -1;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      step();
      n_cmp++;
      if (OUT !== 32'h0) begin n_err++; $display("FAIL reset_out: got %h want %h", OUT, 32'h0); end
      n_cmp++;
      if (ovrflow !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b want 0", ovrflow); end
      n_cmp++;
      if (ready !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b want 0", ready); end
      n_cmp++;
      if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_basic;
      int cyc, bc;
      start_op(32'h0000_0180, 32'h0000_0200);
      wait_ready(cyc, bc);
      n_cmp++;
      if (cyc !== 33) begin n_err++; $display("FAIL basic_latency: got %0d want 33", cyc); end
      n_cmp++;
      if (bc !== 33) begin n_err++; $display("FAIL basic_busy_cycles: got %0d want 33", bc); end
      n_cmp++;
      if (OUT !== 32'h0000_0300) begin n_err++; $display("FAIL basic_out: got %h want %h", OUT, 32'h300); end
      n_cmp++;
      if (ovrflow !== 1'b0) begin n_err++; $display("FAIL basic_ovf: got %b want 0", ovrflow); end
      step();
      n_cmp++;
      if (ready !== 1'b0) begin n_err++; $display("FAIL basic_ready_pulse: got %b want 0", ready); end
      n_cmp++;
      if (OUT !== 32'h0000_0300) begin n_err++; $display("FAIL basic_out_hold: got %h want %h", OUT, 32'h300); end
   endtask

   task automatic test_overflow;
      int cyc, bc;
      start_op(32'h0100_0000, 32'h0001_0000);
      wait_ready(cyc, bc);
      n_cmp++;
      if (OUT !== 32'h0) begin n_err++; $display("FAIL ovf_out: got %h want %h", OUT, 32'h0); end
      n_cmp++;
      if (ovrflow !== 1'b1) begin n_err++; $display("FAIL ovf_flag: got %b want 1", ovrflow); end
      start_op(32'h00FF_FFFF, 32'h0000_0100);
      wait_ready(cyc, bc);
      n_cmp++;
      if (OUT !== 32'h00FF_FFFF) begin n_err++; $display("FAIL ovf_edge_out: got %h want %h", OUT, 32'h00FFFFFF); end
      n_cmp++;
      if (ovrflow !== 1'b0) begin n_err++; $display("FAIL ovf_edge_flag: got %b want 0", ovrflow); end
   endtask

   task automatic test_trunc;
      int cyc, bc;
      start_op(32'h0000_0001, 32'h0000_0080);
      wait_ready(cyc, bc);
      n_cmp++;
      if (OUT !== 32'h0) begin n_err++; $display("FAIL trunc_out: got %h want %h", OUT, 32'h0); end
      n_cmp++;
      if (ovrflow !== 1'b0) begin n_err++; $display("FAIL trunc_ovf: got %b want 0", ovrflow); end
      start_op(32'hFFFF_FFFF, 32'h0000_0100);
      wait_ready(cyc, bc);
      n_cmp++;
      if (OUT !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL ident_out: got %h want %h", OUT, 32'hFFFFFFFF); end
      n_cmp++;
      if (ovrflow !== 1'b0) begin n_err++; $display("FAIL ident_ovf: got %b want 0", ovrflow); end
   endtask

   task automatic test_busy;
      int first_ready, cyc, bc;
      first_ready = -1;
      start_op(32'h0000_0180, 32'h0000_0200);
      for (int i = 1; i <= 40; i++) begin
         if (i == 5 || i == 20) begin
            A = 32'h0000_0200; B = 32'h0000_0200; valid = 1'b1;
         end else begin
            valid = 1'b0;
         end
         step();
         if (ready) begin
            first_ready = i;
            break;
         end
      end
      valid = 1'b0;
      n_cmp++;
      if (first_ready !== 33) begin n_err++; $display("FAIL busy_ignore_latency: got %0d want 33", first_ready); end
      n_cmp++;
      if (OUT !== 32'h0000_0300) begin n_err++; $display("FAIL busy_ignore_out: got %h want %h", OUT, 32'h300); end
      // Request issued in the ready cycle must be accepted.
      start_op(32'h0000_0200, 32'h0000_0200);
      wait_ready(cyc, bc);
      n_cmp++;
      if (cyc !== 33) begin n_err++; $display("FAIL ready_cycle_latency: got %0d want 33", cyc); end
      n_cmp++;
      if (OUT !== 32'h0000_0400) begin n_err++; $display("FAIL ready_cycle_out: got %h want %h", OUT, 32'h400); end
   endtask

   task automatic test_reset_midop;
      int cyc, bc, spurious;
      spurious = 0;
      start_op(32'h0100_0000, 32'h0001_0000);
      for (int i = 0; i < 10; i++) step();
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if (OUT !== 32'h0) begin n_err++; $display("FAIL midrst_out: got %h want %h", OUT, 32'h0); end
      n_cmp++;
      if (busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy: got %b want 0", busy); end
      step();
      step();
      n_cmp++;
      if (ovrflow !== 1'b0) begin n_err++; $display("FAIL midrst_ovf: got %b want 0", ovrflow); end
      rst_n = 1'b1;
      for (int i = 0; i < 40; i++) begin
         step();
         if (ready || busy) spurious++;
      end
      n_cmp++;
      if (spurious !== 0) begin n_err++; $display("FAIL midrst_no_ready: got %0d active cycles want 0", spurious); end
      start_op(32'h0000_0300, 32'h0000_0080);
      wait_ready(cyc, bc);
      n_cmp++;
      if (cyc !== 33) begin n_err++; $display("FAIL postrst_latency: got %0d want 33", cyc); end
      n_cmp++;
      if (OUT !== 32'h0000_0180) begin n_err++; $display("FAIL postrst_out: got %h want %h", OUT, 32'h180); end
   endtask

   task automatic test_back_to_back;
      int cyc, bc;
      logic [31:0] a, b, exp_out;
      logic [63:0] prod;
      logic        exp_ovf;
      for (int k = 0; k < 1000; k++) begin
         a = $urandom >> $urandom_range(0, 31);
         b = $urandom >> $urandom_range(0, 31);
         prod    = 64'(a) * 64'(b);
         exp_out = prod[39:8];
         exp_ovf = |prod[63:40];
         start_op(a, b);
         wait_ready(cyc, bc);
         n_cmp++;
         if (cyc !== 33) begin n_err++; $display("FAIL b2b_latency[%0d]: got %0d want 33", k, cyc); end
         n_cmp++;
         if (OUT !== exp_out) begin n_err++; $display("FAIL b2b_out[%0d] A=%h B=%h: got %h want %h", k, a, b, OUT, exp_out); end
         n_cmp++;
         if (ovrflow !== exp_ovf) begin n_err++; $display("FAIL b2b_ovf[%0d] A=%h B=%h: got %b want %b", k, a, b, ovrflow, exp_ovf); end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_overflow();
      test_trunc();
      test_busy();
      test_reset_midop();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/mul_fp32bit.md
Name: mul_fp32bit

Overview:
Sequential unsigned fixed-point multiplier (Q24.8 × Q24.8 → Q24.8) that performs the inverse operation of the fixed-point divider in the HDR arithmetic path.
- Uses the same valid/ready handshake and overflow flag convention as the divider, so datapath controllers drive both interchangeably.
- Radix-2 shift-add over N cycles; no DSP inference required.

Parameters:
- N, 32, operand/result word width in bits.
- FP, 8, number of fractional bits in operands and result.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- A  in  N  multiplicand, unsigned Q(N-FP).FP.
- B  in  N  multiplier, unsigned Q(N-FP).FP.
- valid  in  1  start request; sampled only when busy=0.
- OUT  out  N  product, truncated to Q(N-FP).FP; held until next completion.
- ovrflow  out  1  product integer part exceeds N-FP bits; held with OUT.
- ready  out  1  one-cycle pulse: OUT/ovrflow valid from this cycle.
- busy  out  1  operation in progress; valid ignored while high.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; OUT=0, ovrflow=0, ready=0, busy=0; internal acc, shift regs, count cleared. Reset mid-operation aborts it; no ready pulse for the aborted request.
- States: IDLE, RUN, DONE.
- IDLE: busy=0. On a rising edge with valid=1:
  - latch a_sh={N'b0,A} (2N bits) and b_sh=B;
  - acc=0, cnt=0; go to RUN.
- RUN (exactly N cycles): busy=1. Each cycle:
  - if b_sh[0], acc<=acc+a_sh;
  - a_sh<=a_sh<<1; b_sh<=b_sh>>1; cnt<=cnt+1.
  - When cnt==N-1, go to DONE.
- DONE (1 cycle): busy=1.
  - OUT<=acc[N+FP-1:FP]; ovrflow<=|acc[2N-1:N+FP].
  - Go to IDLE.
  - ready is a registered pulse, high for the one cycle after DONE, coincident with updated OUT.
- Latency: valid sampled at edge k → ready high during cycle after edge k+N+1 (33 clocks for N=32). Throughput: one result per N+2 cycles.
- valid while busy=1: ignored, not queued. valid in the same cycle ready is high: accepted, because the state is IDLE.
- Arithmetic: full 2N-bit unsigned product, with no loss in acc. The result is truncated toward zero (the lower FP bits are discarded, with no rounding).
- ovrflow reflects only truncated high bits. OUT still carries the low N bits of the shifted product (wrapped, not saturated).
- OUT and ovrflow change only on DONE or reset. Between operations they hold the last result.
- Zero operands: no early termination; latency is fixed.

Decomposition:
- Shared fixed-point package/include (common with div_fp32bit):
  - N=32 and FP=8 constants;
  - state encoding localparams IDLE/RUN/DONE.
- Counter width = clog2(N) bits.
- Single flat module. No sub-module is needed; the shift-add datapath is about 20 lines and does not justify a separate mul_step instance.

Test Plan:
- Basic multiply: A=0x00000180 (1.5), B=0x00000200 (2.0), valid pulse → ready exactly 33 cycles later, OUT=0x00000300, ovrflow=0, busy high for 33 cycles.
- Overflow: A=0x01000000 (65536.0), B=0x00010000 (256.0) → OUT=0x00000000, ovrflow=1. Then A=0x00FFFFFF, B=0x00000100 → OUT=0x00FFFFFF, ovrflow=0.
- Truncation and identity:
  - A=0x00000001, B=0x00000080 → OUT=0x00000000, ovrflow=0.
  - A=0xFFFFFFFF, B=0x00000100 (1.0) → OUT=0xFFFFFFFF, ovrflow=0.
- Busy handling: valid re-asserted with A=B=0x00000200 at cycles 5 and 20 of a running 1.5×2.0 operation → single ready pulse, OUT=0x00000300. Valid in the ready cycle starts a new op, whose result 0x00000400 arrives 33 cycles later.
- Reset mid-op: rst_n low for 2 cycles at RUN cycle 10 → OUT=0, ovrflow=0, busy=0, no ready pulse. Next op 3.0×0.5 (0x300, 0x080) → OUT=0x00000180 after 33 cycles.
- Back-to-back random: 1000 random A/B, each issued on ready → OUT==(A*B>>8)[31:0] and ovrflow==|(A*B)[63:40] against a 64-bit reference model.
